control_sequencer: RTL and testbench

Hardwired control unit driving the CPU datapath's control inputs. It walks a fetch/execute step counter and decodes the opcode in IR[31:27]. Each cycle it emits the register-transfer controls: bus drivers, register/Y/Z/MAR/MDR/PC/IR/HI/LO loads, RAM read/write, ALU op, Gra/Grb/Grc select, CON latch, and I/O enables. It samples the datapath's IR and CON flip-flop outputs and closes the instruction loop around the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/control_decode.sv | 45 ++++
 rtl/control_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the hardwired CPU control unit:
// opcodes, ALU function codes, sequencer modes and instruction classes.
package cpu_ctrl_pkg;

   localparam int STEP_W = 4;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_ROR  = 4'd4;
   localparam logic [3:0] ALU_ROL  = 4'd5;
   localparam logic [3:0] ALU_SHR  = 4'd6;
   localparam logic [3:0] ALU_SHRA = 4'd7;
   localparam logic [3:0] ALU_SHL  = 4'd8;
   localparam logic [3:0] ALU_MUL  = 4'd9;
   localparam logic [3:0] ALU_DIV  = 4'd10;
   localparam logic [3:0] ALU_NEG  = 4'd11;
   localparam logic [3:0] ALU_NOT  = 4'd12;
   localparam logic [3:0] ALU_INC  = 4'd13;

   localparam logic [STEP_W-1:0] T0 = 4'd0;
   localparam logic [STEP_W-1:0] T1 = 4'd1;
   localparam logic [STEP_W-1:0] T2 = 4'd2;
   localparam logic [STEP_W-1:0] T3 = 4'd3;
   localparam logic [STEP_W-1:0] T4 = 4'd4;
   localparam logic [STEP_W-1:0] T5 = 4'd5;
   localparam logic [STEP_W-1:0] T6 = 4'd6;
   localparam logic [STEP_W-1:0] T7 = 4'd7;
   localparam logic [STEP_W-1:0] T8 = 4'd8;
   localparam logic [STEP_W-1:0] T9 = 4'd9;

   typedef enum logic [1:0] {MODE_RESET, MODE_RUN, MODE_HALT} mode_t;

   typedef enum logic [3:0] {
      CLS_RALU, CLS_IALU, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
      CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
   } iclass_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps IR[31:27] to an instruction class
// and the ALU function that class uses during execute.
module control_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] opcode,
   output iclass_t    iclass,
   output logic [3:0] alu_op
);

   always_comb begin
      iclass = CLS_NOP;
      alu_op = ALU_ADD;
      case (opcode)
         OP_ADD:  begin iclass = CLS_RALU;   alu_op = ALU_ADD;  end
         OP_SUB:  begin iclass = CLS_RALU;   alu_op = ALU_SUB;  end
         OP_AND:  begin iclass = CLS_RALU;   alu_op = ALU_AND;  end
         OP_OR:   begin iclass = CLS_RALU;   alu_op = ALU_OR;   end
         OP_ROR:  begin iclass = CLS_RALU;   alu_op = ALU_ROR;  end
         OP_ROL:  begin iclass = CLS_RALU;   alu_op = ALU_ROL;  end
         OP_SHR:  begin iclass = CLS_RALU;   alu_op = ALU_SHR;  end
         OP_SHRA: begin iclass = CLS_RALU;   alu_op = ALU_SHRA; end
         OP_SHL:  begin iclass = CLS_RALU;   alu_op = ALU_SHL;  end
         OP_ADDI: begin iclass = CLS_IALU;   alu_op = ALU_ADD;  end
         OP_ANDI: begin iclass = CLS_IALU;   alu_op = ALU_AND;  end
         OP_ORI:  begin iclass = CLS_IALU;   alu_op = ALU_OR;   end
         OP_NEG:  begin iclass = CLS_UNARY;  alu_op = ALU_NEG;  end
         OP_NOT:  begin iclass = CLS_UNARY;  alu_op = ALU_NOT;  end
         OP_MUL:  begin iclass = CLS_MULDIV; alu_op = ALU_MUL;  end
         OP_DIV:  begin iclass = CLS_MULDIV; alu_op = ALU_DIV;  end
         OP_LD:   iclass = CLS_LD;
         OP_LDI:  iclass = CLS_LDI;
         OP_ST:   iclass = CLS_ST;
         OP_BR:   iclass = CLS_BR;
         OP_JR:   iclass = CLS_JR;
         OP_IN:   iclass = CLS_IN;
         OP_OUT:  iclass = CLS_OUT;
         OP_MFHI: iclass = CLS_MFHI;
         OP_MFLO: iclass = CLS_MFLO;
         OP_HALT: iclass = CLS_HALT;
         default: iclass = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: a {mode, step} register walks each
// instruction, and every datapath control is decoded from that state.
module control_sequencer
   import cpu_ctrl_pkg::*;
(
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        CON,
   input  logic        Stop,
   output logic        Run,
   output logic        PCout,
   output logic        IncPC,
   output logic        PCin,
   output logic        IRin,
   output logic        Yin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        Read,
   output logic        wren,
   output logic        HIin,
   output logic        HIout,
   output logic        LOin,
   output logic        LOout,
   output logic        Zhighin,
   output logic        Zlowin,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        Cout,
   output logic        InPortout,
   output logic        outPortEnable,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        conInput,
   output logic        IRout,
   output logic [3:0]  ctrl
);

   mode_t             mode;
   logic [STEP_W-1:0] step;
   logic [STEP_W-1:0] last_step;
   iclass_t           iclass;
   logic [3:0]        alu_op;
   logic              unused_ir;

   assign unused_ir = ^IR[26:0];

   control_decode u_decode (
      .opcode (IR[31:27]),
      .iclass (iclass),
      .alu_op (alu_op)
   );

   // Final step of each class; nop and halt end right after the fetch.
   always_comb begin
      last_step = T3;
      case (iclass)
         CLS_RALU, CLS_IALU, CLS_LDI:             last_step = T6;
         CLS_UNARY:                               last_step = T5;
         CLS_MULDIV, CLS_BR:                      last_step = T7;
         CLS_LD:                                  last_step = T9;
         CLS_ST:                                  last_step = T8;
         CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: last_step = T4;
         default:                                 last_step = T3;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         mode <= MODE_RESET;
         step <= T0;
      end else begin
         case (mode)
            MODE_RESET: begin
               mode <= MODE_RUN;
               step <= T0;
            end
            MODE_RUN: begin
               if (step == last_step) begin
                  step <= T0;
                  if (Stop || iclass == CLS_HALT) mode <= MODE_HALT;
               end else begin
                  step <= step + 1'b1;
               end
            end
            default: begin
               mode <= MODE_HALT;
               step <= T0;
            end
         endcase
      end
   end

   assign Run = (mode == MODE_RUN);

   always_comb begin
      PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; IRin = 1'b0; Yin = 1'b0;
      MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; wren = 1'b0;
      HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0;
      Zhighin = 1'b0; Zlowin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
      Cout = 1'b0; InPortout = 1'b0; outPortEnable = 1'b0;
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
      BAout = 1'b0; conInput = 1'b0; IRout = 1'b0;
      ctrl = ALU_ADD;
      if (mode == MODE_RUN) begin
         case (step)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ctrl = ALU_INC; Zlowin = 1'b1; end
            T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; end
            T2: begin Read = 1'b1; MDRin = 1'b1; end
            T3: begin MDRout = 1'b1; IRin = 1'b1; end
            default: begin
               case (iclass)
                  CLS_RALU, CLS_IALU: begin
                     case (step)
                        T4: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        T5: begin
                           if (iclass == CLS_IALU) begin
                              Cout = 1'b1;
                           end else begin
                              Grc = 1'b1; Rout = 1'b1;
                           end
                           ctrl = alu_op; Zlowin = 1'b1;
                        end
                        T6: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                     endcase
                  end
                  CLS_UNARY: begin
                     case (step)
                        T4: begin Grb = 1'b1; Rout = 1'b1; ctrl = alu_op; Zlowin = 1'b1; end
                        T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                     endcase
                  end
                  CLS_MULDIV: begin
                     case (step)
                        T4: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        T5: begin Grb = 1'b1; Rout = 1'b1; ctrl = alu_op; Zhighin = 1'b1; Zlowin = 1'b1; end
                        T6: begin Zlowout = 1'b1; LOin = 1'b1; end
                        T7: begin Zhighout = 1'b1; HIin = 1'b1; end
                        default: ;
                     endcase
                  end
                  // ld/ldi/st share the base+offset address calculation.
                  CLS_LD, CLS_LDI, CLS_ST: begin
                     case (step)
                        T4: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        T5: begin Cout = 1'b1; Zlowin = 1'b1; end
                        T6: begin
                           Zlowout = 1'b1;
                           if (iclass == CLS_LDI) begin
                              Gra = 1'b1; Rin = 1'b1;
                           end else begin
                              MARin = 1'b1;
                           end
                        end
                        T7: begin
                           if (iclass == CLS_LD) Read = 1'b1;
                           if (iclass == CLS_ST) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                        end
                        T8: begin
                           if (iclass == CLS_LD) begin Read = 1'b1; MDRin = 1'b1; end
                           if (iclass == CLS_ST) wren = 1'b1;
                        end
                        T9: if (iclass == CLS_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                     endcase
                  end
                  CLS_BR: begin
                     case (step)
                        T4: begin Gra = 1'b1; Rout = 1'b1; conInput = 1'b1; end
                        T5: begin PCout = 1'b1; Yin = 1'b1; end
                        T6: begin Cout = 1'b1; Zlowin = 1'b1; end
                        T7: begin Zlowout = 1'b1; PCin = CON; end
                        default: ;
                     endcase
                  end
                  CLS_JR:   if (step == T4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  CLS_IN:   if (step == T4) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  CLS_OUT:  if (step == T4) begin Gra = 1'b1; Rout = 1'b1; outPortEnable = 1'b1; end
                  CLS_MFHI: if (step == T4) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  CLS_MFLO: if (step == T4) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction's expected per-cycle control words
// are built as a queue from the instruction tables and compared cycle by cycle.
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Clear, CON, Stop, Run;
   logic [31:0] IR;
   logic        PCout, IncPC, PCin, IRin, Yin, MARin, MDRin, MDRout, Read, wren;
   logic        HIin, HIout, LOin, LOout, Zhighin, Zlowin, Zhighout, Zlowout;
   logic        Cout, InPortout, outPortEnable, Gra, Grb, Grc, Rin, Rout;
   logic        BAout, conInput, IRout;
   logic [3:0]  ctrl;

   int checks_done = 0;
   int failures    = 0;

   logic [33:0] exp_q[$];
   logic [33:0] dut_word;

   localparam logic [28:0] B_PCOUT = 29'h1 << 0,  B_INCPC = 29'h1 << 1,  B_PCIN = 29'h1 << 2;
   localparam logic [28:0] B_IRIN = 29'h1 << 3,   B_YIN = 29'h1 << 4,    B_MARIN = 29'h1 << 5;
   localparam logic [28:0] B_MDRIN = 29'h1 << 6,  B_MDROUT = 29'h1 << 7, B_READ = 29'h1 << 8;
   localparam logic [28:0] B_WREN = 29'h1 << 9,   B_HIIN = 29'h1 << 10,  B_HIOUT = 29'h1 << 11;
   localparam logic [28:0] B_LOIN = 29'h1 << 12,  B_LOOUT = 29'h1 << 13, B_ZHIN = 29'h1 << 14;
   localparam logic [28:0] B_ZLIN = 29'h1 << 15,  B_ZHOUT = 29'h1 << 16, B_ZLOUT = 29'h1 << 17;
   localparam logic [28:0] B_COUT = 29'h1 << 18,  B_INPORT = 29'h1 << 19, B_OUTPORT = 29'h1 << 20;
   localparam logic [28:0] B_GRA = 29'h1 << 21,   B_GRB = 29'h1 << 22,   B_GRC = 29'h1 << 23;
   localparam logic [28:0] B_RIN = 29'h1 << 24,   B_ROUT = 29'h1 << 25,  B_BAOUT = 29'h1 << 26;
   localparam logic [28:0] B_CONIN = 29'h1 << 27;

   control_sequencer dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
      .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .IRin(IRin), .Yin(Yin),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .wren(wren),
      .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
      .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .Cout(Cout), .InPortout(InPortout), .outPortEnable(outPortEnable),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .BAout(BAout), .conInput(conInput), .IRout(IRout), .ctrl(ctrl)
   );

   always #5 Clock = ~Clock;

   assign dut_word = {Run, ctrl, IRout, conInput, BAout, Rout, Rin, Grc, Grb, Gra,
                      outPortEnable, InPortout, Cout, Zlowout, Zhighout, Zlowin, Zhighin,
                      LOout, LOin, HIout, HIin, wren, Read, MDRout, MDRin, MARin,
                      Yin, IRin, PCin, IncPC, PCout};

   task automatic checkOutput(input string tag, input logic [33:0] observed, input logic [33:0] expected);
      checks_done++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed 0x%09h required 0x%09h", tag, observed, expected);
      end
   endtask

   function automatic logic [33:0] cw(input logic [28:0] flags, input logic [3:0] op);
      return {1'b1, op, flags};
   endfunction

   // Expected control-word sequence of one complete instruction, fetch included.
   task automatic build_expected(input logic [4:0] op, input bit con);
      logic [3:0] fn;
      exp_q.delete();
      exp_q.push_back(cw(B_PCOUT | B_MARIN | B_INCPC | B_ZLIN, 4'd13));
      exp_q.push_back(cw(B_ZLOUT | B_PCIN | B_READ, 4'd0));
      exp_q.push_back(cw(B_READ | B_MDRIN, 4'd0));
      exp_q.push_back(cw(B_MDROUT | B_IRIN, 4'd0));
      if (op >= 5'd3 && op <= 5'd11) begin
         fn = 4'(op - 5'd3);
         exp_q.push_back(cw(B_GRB | B_ROUT | B_YIN, 4'd0));
         exp_q.push_back(cw(B_GRC | B_ROUT | B_ZLIN, fn));
         exp_q.push_back(cw(B_ZLOUT | B_GRA | B_RIN, 4'd0));
      end else if (op >= 5'd12 && op <= 5'd14) begin
         fn = (op == 5'd12) ? 4'd0 : (op == 5'd13) ? 4'd2 : 4'd3;
         exp_q.push_back(cw(B_GRB | B_ROUT | B_YIN, 4'd0));
         exp_q.push_back(cw(B_COUT | B_ZLIN, fn));
         exp_q.push_back(cw(B_ZLOUT | B_GRA | B_RIN, 4'd0));
      end else if (op == 5'd17 || op == 5'd18) begin
         exp_q.push_back(cw(B_GRB | B_ROUT | B_ZLIN, (op == 5'd17) ? 4'd11 : 4'd12));
         exp_q.push_back(cw(B_ZLOUT | B_GRA | B_RIN, 4'd0));
      end else if (op == 5'd15 || op == 5'd16) begin
         exp_q.push_back(cw(B_GRA | B_ROUT | B_YIN, 4'd0));
         exp_q.push_back(cw(B_GRB | B_ROUT | B_ZHIN | B_ZLIN, (op == 5'd16) ? 4'd9 : 4'd10));
         exp_q.push_back(cw(B_ZLOUT | B_LOIN, 4'd0));
         exp_q.push_back(cw(B_ZHOUT | B_HIIN, 4'd0));
      end else if (op <= 5'd2) begin
         exp_q.push_back(cw(B_GRB | B_BAOUT | B_YIN, 4'd0));
         exp_q.push_back(cw(B_COUT | B_ZLIN, 4'd0));
         if (op == 5'd1) begin
            exp_q.push_back(cw(B_ZLOUT | B_GRA | B_RIN, 4'd0));
         end else begin
            exp_q.push_back(cw(B_ZLOUT | B_MARIN, 4'd0));
            if (op == 5'd0) begin
               exp_q.push_back(cw(B_READ, 4'd0));
               exp_q.push_back(cw(B_READ | B_MDRIN, 4'd0));
               exp_q.push_back(cw(B_MDROUT | B_GRA | B_RIN, 4'd0));
            end else begin
               exp_q.push_back(cw(B_GRA | B_ROUT | B_MDRIN, 4'd0));
               exp_q.push_back(cw(B_WREN, 4'd0));
            end
         end
      end else if (op == 5'd19) begin
         exp_q.push_back(cw(B_GRA | B_ROUT | B_CONIN, 4'd0));
         exp_q.push_back(cw(B_PCOUT | B_YIN, 4'd0));
         exp_q.push_back(cw(B_COUT | B_ZLIN, 4'd0));
         exp_q.push_back(cw(B_ZLOUT | (con ? B_PCIN : 29'h0), 4'd0));
      end else if (op == 5'd21) exp_q.push_back(cw(B_GRA | B_ROUT | B_PCIN, 4'd0));
      else if (op == 5'd22) exp_q.push_back(cw(B_INPORT | B_GRA | B_RIN, 4'd0));
      else if (op == 5'd23) exp_q.push_back(cw(B_GRA | B_ROUT | B_OUTPORT, 4'd0));
      else if (op == 5'd24) exp_q.push_back(cw(B_HIOUT | B_GRA | B_RIN, 4'd0));
      else if (op == 5'd25) exp_q.push_back(cw(B_LOOUT | B_GRA | B_RIN, 4'd0));
   endtask

   task automatic applyStimulus(input logic [4:0] op, input bit con);
      IR  = {op, 27'($urandom)};
      CON = con;
   endtask

   // Leaves the DUT halted for a while, then restarts it through Clear.
   task automatic check_halt_and_restart(input string name);
      for (int k = 0; k < 20; k++) begin
         checkOutput($sformatf("%s halted c%0d", name, k), dut_word, 34'h0);
         @(negedge Clock);
      end
      Clear = 1'b1;
      @(negedge Clock);
      checkOutput($sformatf("%s clear", name), dut_word, 34'h0);
      Clear = 1'b0;
      @(negedge Clock);
   endtask

   // Called with the DUT at T0; returns with the DUT at the next T0.
   task automatic run_instr(input string name, input logic [4:0] op, input bit con,
                            input bit stop_final, input int stop_at);
      int  n;
      bit  halts;
      applyStimulus(op, con);
      build_expected(op, con);
      n = exp_q.size();
      halts = (op == 5'd27) || stop_final || (stop_at == n - 1);
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s T%0d", name, i), dut_word, exp_q[i]);
         Stop = ((i == n - 1) && stop_final) || (i == stop_at);
         @(negedge Clock);
      end
      Stop = 1'b0;
      if (halts) check_halt_and_restart(name);
   endtask

   task automatic run_st_abort();
      applyStimulus(5'd2, 1'b0);
      build_expected(5'd2, 1'b0);
      for (int i = 0; i <= 7; i++) begin
         checkOutput($sformatf("st_abort T%0d", i), dut_word, exp_q[i]);
         if (i == 7) Clear = 1'b1;
         @(negedge Clock);
      end
      checkOutput("st_abort wren", {33'h0, wren}, 34'h0);
      checkOutput("st_abort reset", dut_word, 34'h0);
      Clear = 1'b0;
      @(negedge Clock);
   endtask

   initial begin
      logic [4:0] rop;
      int         sat;
      Clear = 1'b1; Stop = 1'b0; CON = 1'b0; IR = 32'h0;
      repeat (2) begin
         @(negedge Clock);
         checkOutput("reset", dut_word, 34'h0);
      end
      Clear = 1'b0;
      @(negedge Clock);

      run_instr("add", 5'd3, 1'b0, 1'b0, -1);
      run_instr("st", 5'd2, 1'b0, 1'b0, -1);
      run_st_abort();
      run_instr("br_taken", 5'd19, 1'b1, 1'b0, -1);
      run_instr("br_not", 5'd19, 1'b0, 1'b0, -1);
      run_instr("mul", 5'd16, 1'b0, 1'b0, -1);
      run_instr("ldi_stop_t5", 5'd1, 1'b0, 1'b0, 5);
      run_instr("ldi_stop_end", 5'd1, 1'b0, 1'b1, -1);
      run_instr("halt", 5'd27, 1'b0, 1'b0, -1);
      run_instr("nop", 5'd26, 1'b0, 1'b0, -1);
      run_instr("ld", 5'd0, 1'b0, 1'b0, -1);

      for (int r = 0; r < 60; r++) begin
         rop = 5'($urandom_range(0, 31));
         sat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
         run_instr($sformatf("rnd%0d_op%0d", r, rop), rop, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0), sat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks_done, failures);
      $finish;
   end

endmodule
